// File: rtl/spi_burst_seq.sv
// Byte-burst sequencer in front of the SPI peripheral register port.
// Takes a burst command plus a TX byte stream and performs, per byte, one
// data write and one data read on the SPI block, framing the burst with
// chip-select writes. Received bytes are presented on an RX stream unless
// the command asked for them to be discarded.
module spi_burst_seq #(
   parameter int LEN_W = 9
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             cmd_hold_cs,
   input  logic             cmd_rx_discard,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [7:0]       tx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [7:0]       rx_data,
   output logic             done,
   output logic             busy,
   output logic             spi_ctrl,
   output logic [31:0]      spi_wdata,
   output logic [3:0]       spi_wstrb,
   output logic             spi_valid,
   input  logic             spi_ready,
   input  logic [31:0]      spi_rdata
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CS_ON  = 3'd1,
      S_LOAD   = 3'd2,
      S_WR     = 3'd3,
      S_RD     = 3'd4,
      S_PUSH   = 3'd5,
      S_CS_OFF = 3'd6,
      S_GAP    = 3'd7
   } state_e;

   localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   state_e           gap_next_q, gap_next_d;
   logic             cs_active_q, cs_active_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic             hold_q, hold_d;
   logic             discard_q, discard_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             done_q, done_d;
   logic             spi_valid_q, spi_valid_d;
   logic             spi_ctrl_q, spi_ctrl_d;
   logic [31:0]      spi_wdata_q, spi_wdata_d;
   logic [3:0]       spi_wstrb_q, spi_wstrb_d;
   logic             access_done_s;

   // Only the RX byte lane of the SPI read data is meaningful here.
   logic             unused_rdata_s;
   assign unused_rdata_s = ^spi_rdata[31:8];

   // After a byte completes: fetch another, finish with CS held, or release CS.
   function automatic state_e next_byte_state(input logic [LEN_W-1:0] rem,
                                              input logic             hold);
      state_e nxt;
      if (rem != LEN_ZERO) begin
         nxt = S_LOAD;
      end else if (hold) begin
         nxt = S_IDLE;
      end else begin
         nxt = S_CS_OFF;
      end
      return nxt;
   endfunction

   // Handshake-decoded outputs come straight from the current state.
   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign tx_ready  = (state_q == S_LOAD);

   assign rx_valid  = rx_valid_q;
   assign rx_data   = rx_data_q;
   assign done      = done_q;
   assign spi_valid = spi_valid_q;
   assign spi_ctrl  = spi_ctrl_q;
   assign spi_wdata = spi_wdata_q;
   assign spi_wstrb = spi_wstrb_q;

   // Next-state logic and burst bookkeeping.
   always_comb begin
      state_d       = state_q;
      gap_next_d    = gap_next_q;
      cs_active_d   = cs_active_q;
      remaining_d   = remaining_q;
      tx_byte_d     = tx_byte_q;
      hold_d        = hold_q;
      discard_d     = discard_q;
      rx_data_d     = rx_data_q;
      done_d        = 1'b0;
      access_done_s = spi_valid_q & spi_ready;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               hold_d      = cmd_hold_cs;
               discard_d   = cmd_rx_discard;
               remaining_d = cmd_len;
               if (cmd_len == LEN_ZERO) begin
                  if (cs_active_q && !cmd_hold_cs) begin
                     state_d = S_CS_OFF;
                  end else begin
                     done_d = 1'b1;
                  end
               end else if (!cs_active_q) begin
                  state_d = S_CS_ON;
               end else begin
                  state_d = S_LOAD;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CS_ON: begin
            if (access_done_s) begin
               cs_active_d = 1'b1;
               gap_next_d  = S_LOAD;
               state_d     = S_GAP;
            end else begin
               state_d = S_CS_ON;
            end
         end
         S_LOAD: begin
            if (tx_valid) begin
               tx_byte_d = tx_data;
               state_d   = S_WR;
            end else begin
               state_d = S_LOAD;
            end
         end
         S_WR: begin
            if (access_done_s) begin
               gap_next_d = S_RD;
               state_d    = S_GAP;
            end else begin
               state_d = S_WR;
            end
         end
         S_RD: begin
            if (access_done_s) begin
               if (remaining_q != LEN_ZERO) begin
                  remaining_d = remaining_q - LEN_ONE;
               end else begin
                  remaining_d = remaining_q;
               end
               if (!discard_q) begin
                  rx_data_d  = spi_rdata[7:0];
                  gap_next_d = S_PUSH;
               end else begin
                  gap_next_d = next_byte_state(remaining_d, hold_q);
               end
               state_d = S_GAP;
            end else begin
               state_d = S_RD;
            end
         end
         S_PUSH: begin
            if (rx_ready) begin
               state_d = next_byte_state(remaining_q, hold_q);
               done_d  = (state_d == S_IDLE);
            end else begin
               state_d = S_PUSH;
            end
         end
         S_CS_OFF: begin
            if (access_done_s) begin
               cs_active_d = 1'b0;
               gap_next_d  = S_IDLE;
               state_d     = S_GAP;
            end else begin
               state_d = S_CS_OFF;
            end
         end
         S_GAP: begin
            // The SPI data path keeps ready high for the whole shift, so the
            // next access must not start until ready has been seen low.
            if (!spi_ready) begin
               state_d = gap_next_q;
               done_d  = (gap_next_q == S_IDLE);
            end else begin
               state_d = S_GAP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Registered SPI request and RX-valid, derived from the state being entered
   // so that valid rises together with the access state.
   always_comb begin
      spi_valid_d = 1'b0;
      spi_ctrl_d  = spi_ctrl_q;
      spi_wdata_d = spi_wdata_q;
      spi_wstrb_d = spi_wstrb_q;
      rx_valid_d  = (state_d == S_PUSH);

      case (state_d)
         S_CS_ON: begin
            spi_valid_d = 1'b1;
            spi_ctrl_d  = 1'b0;
            spi_wstrb_d = 4'b0001;
            spi_wdata_d = 32'h0000_0001;
         end
         S_WR: begin
            spi_valid_d = 1'b1;
            spi_ctrl_d  = 1'b1;
            spi_wstrb_d = 4'b0001;
            spi_wdata_d = {24'h00_0000, tx_byte_d};
         end
         S_RD: begin
            spi_valid_d = 1'b1;
            spi_ctrl_d  = 1'b1;
            spi_wstrb_d = 4'b0000;
         end
         S_CS_OFF: begin
            spi_valid_d = 1'b1;
            spi_ctrl_d  = 1'b0;
            spi_wstrb_d = 4'b0001;
            spi_wdata_d = 32'h0000_0000;
         end
         default: begin
            spi_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset returns everything to idle at once.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         gap_next_q  <= S_IDLE;
         cs_active_q <= 1'b0;
         remaining_q <= LEN_ZERO;
         tx_byte_q   <= 8'h00;
         hold_q      <= 1'b0;
         discard_q   <= 1'b0;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         done_q      <= 1'b0;
         spi_valid_q <= 1'b0;
         spi_ctrl_q  <= 1'b0;
         spi_wdata_q <= 32'h0000_0000;
         spi_wstrb_q <= 4'b0000;
      end else begin
         state_q     <= state_d;
         gap_next_q  <= gap_next_d;
         cs_active_q <= cs_active_d;
         remaining_q <= remaining_d;
         tx_byte_q   <= tx_byte_d;
         hold_q      <= hold_d;
         discard_q   <= discard_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         done_q      <= done_d;
         spi_valid_q <= spi_valid_d;
         spi_ctrl_q  <= spi_ctrl_d;
         spi_wdata_q <= spi_wdata_d;
         spi_wstrb_q <= spi_wstrb_d;
      end
   end

endmodule

// File: tb/tb_spi_burst_seq.sv
// Scoreboard bench for spi_burst_seq: a command-level reference model pushes
// the expected SPI access sequence, RX bytes and done pulses; independent
// monitors pop and compare as the DUT produces them.
module tb_spi_burst_seq;
   localparam int LEN_W = 9;

   logic             clk;
   logic             resetn;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [LEN_W-1:0] cmd_len;
   logic             cmd_hold_cs;
   logic             cmd_rx_discard;
   logic             tx_valid;
   logic             tx_ready;
   logic [7:0]       tx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic [7:0]       rx_data;
   logic             done;
   logic             busy;
   logic             spi_ctrl;
   logic [31:0]      spi_wdata;
   logic [3:0]       spi_wstrb;
   logic             spi_valid;
   logic             spi_ready;
   logic [31:0]      spi_rdata;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;
   bit model_cs = 1'b0;
   bit long_hold = 1'b0;
   int rx_mode  = 0;
   int done_pend = 0;

   logic [36:0] exp_acc_q[$];
   logic [7:0]  exp_rx_q[$];
   logic [7:0]  tx_stim_q[$];
   logic [7:0]  fixed_tx_q[$];

   spi_burst_seq #(.LEN_W(LEN_W)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .cmd_hold_cs(cmd_hold_cs), .cmd_rx_discard(cmd_rx_discard),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .done(done), .busy(busy),
      .spi_ctrl(spi_ctrl), .spi_wdata(spi_wdata), .spi_wstrb(spi_wstrb),
      .spi_valid(spi_valid), .spi_ready(spi_ready), .spi_rdata(spi_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no end of test, expected finish before time limit");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: got unexpected event or timeout, expected none at %0t", name, $time);
   endtask

   function automatic logic [36:0] acc(input logic c, input logic [3:0] s, input logic [31:0] d);
      return {c, s, d};
   endfunction

   function automatic logic [50:0] outs();
      return {cmd_ready, busy, done, tx_ready, rx_valid, rx_data,
              spi_valid, spi_ctrl, spi_wdata, spi_wstrb};
   endfunction

   // SPI peripheral model: acknowledges after a random latency, echoes the
   // last written data byte inverted on reads, may hold ready after the access.
   initial begin : spi_model
      logic [36:0] cur;
      logic [7:0]  last_tx;
      int unsigned rnd;
      int          lat;
      int          hold;
      spi_ready = 1'b0;
      spi_rdata = 32'h0;
      last_tx   = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (spi_valid && !spi_ready) begin
            cur = {spi_ctrl, spi_wstrb, spi_wdata};
            if (chk_en) begin
               if (exp_acc_q.size() == 0) fail("unexpected_spi_access");
               else chk("spi_access", 64'(cur), 64'(exp_acc_q.pop_front()));
            end
            lat = int'($urandom_range(0, 3));
            repeat (lat) begin
               @(posedge clk); #1;
               if (chk_en) begin
                  chk("spi_valid_held", 64'(spi_valid), 64'(1));
                  chk("spi_fields_stable", 64'({spi_ctrl, spi_wstrb, spi_wdata}), 64'(cur));
               end
            end
            if (cur[35:32] == 4'b0000) begin
               rnd = $urandom();
               spi_rdata = {rnd[23:0], last_tx ^ 8'hFF};
            end else if (cur[36]) begin
               last_tx = cur[7:0];
            end
            spi_ready = 1'b1;
            @(posedge clk); #1;
            if (chk_en) chk("spi_valid_drop", 64'(spi_valid), 64'(0));
            if (long_hold && cur[36] && cur[35:32] != 4'b0000) hold = 50;
            else hold = int'($urandom_range(0, 2));
            repeat (hold) begin
               @(posedge clk); #1;
               if (chk_en) chk("no_req_while_ready", 64'(spi_valid), 64'(0));
            end
            spi_ready = 1'b0;
         end
      end
   end

   // TX stream source: presents queued bytes with random idle gaps.
   initial begin : tx_driver
      bit fire;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      forever begin
         @(negedge clk);
         fire = tx_valid && tx_ready;
         @(posedge clk); #1;
         if (fire) begin
            tx_stim_q.delete(0);
            tx_valid = 1'b0;
         end
         if (!tx_valid && tx_stim_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            tx_valid = 1'b1;
            tx_data  = tx_stim_q[0];
         end
      end
   end

   // RX sink: always ready, random backpressure, or one 20-cycle stall.
   initial begin : rx_driver
      rx_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (rx_mode == 2) begin
            rx_ready = 1'b0;
            if (rx_valid) begin
               repeat (20) begin @(posedge clk); #1; end
               rx_ready = 1'b1;
               rx_mode  = 0;
            end
         end else if (rx_mode == 1) begin
            rx_ready = ($urandom_range(0, 1) == 1);
         end else begin
            rx_ready = 1'b1;
         end
      end
   end

   // RX / done monitor.
   initial begin : rx_monitor
      bit         pv;
      bit         pf;
      logic [7:0] pd;
      pv = 1'b0; pf = 1'b0; pd = 8'h00;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            if (pv && !pf) begin
               chk("rx_valid_held", 64'(rx_valid), 64'(1));
               chk("rx_data_stable", 64'(rx_data), 64'(pd));
            end
            if (rx_valid) begin
               chk("no_spi_during_push", 64'(spi_valid), 64'(0));
               if (rx_ready) begin
                  if (exp_rx_q.size() == 0) fail("unexpected_rx");
                  else chk("rx_data", 64'(rx_data), 64'(exp_rx_q.pop_front()));
               end
            end
            if (done) begin
               chk("busy_at_done", 64'(busy), 64'(0));
               chk("drained_at_done", 64'(exp_acc_q.size() + exp_rx_q.size()), 64'(0));
               if (done_pend == 0) fail("unexpected_done");
               else done_pend--;
            end
         end
         pv = rx_valid;
         pf = rx_valid && rx_ready;
         pd = rx_data;
      end
   end

   // Issue one command: model its effects, then drive the handshake.
   task automatic issue(input int len, input bit hold, input bit disc);
      bit         cs_before;
      logic [7:0] b;
      int         n;
      n = 0;
      while (!(cmd_ready && done_pend == 0) && n < 40000) begin
         @(negedge clk);
         n++;
      end
      if (!(cmd_ready && done_pend == 0)) fail("issue_wait_timeout");
      cs_before = model_cs;
      if (len == 0) begin
         if (model_cs && !hold) begin
            exp_acc_q.push_back(acc(1'b0, 4'b0001, 32'h0));
            model_cs = 1'b0;
         end
      end else begin
         if (!model_cs) begin
            exp_acc_q.push_back(acc(1'b0, 4'b0001, 32'h1));
            model_cs = 1'b1;
         end
         for (int i = 0; i < len; i++) begin
            if (fixed_tx_q.size() > 0) b = fixed_tx_q.pop_front();
            else b = 8'($urandom());
            tx_stim_q.push_back(b);
            exp_acc_q.push_back(acc(1'b1, 4'b0001, {24'h0, b}));
            exp_acc_q.push_back(acc(1'b1, 4'b0000, 32'h0) | (37'(spi_wdata_dc_mask())));
            if (!disc) exp_rx_q.push_back(b ^ 8'hFF);
         end
         if (!hold) begin
            exp_acc_q.push_back(acc(1'b0, 4'b0001, 32'h0));
            model_cs = 1'b0;
         end
      end
      done_pend++;
      @(posedge clk); #1;
      cmd_valid      = 1'b1;
      cmd_len        = len[LEN_W-1:0];
      cmd_hold_cs    = hold;
      cmd_rx_discard = disc;
      @(negedge clk);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      if (len != 0 && !cs_before)
         chk("cmd_to_cs_on", 64'({busy, spi_valid, spi_ctrl, spi_wdata}), 64'({1'b1, 1'b1, 1'b0, 32'h1}));
      else if (len != 0)
         chk("cmd_to_load", 64'({busy, tx_ready, spi_valid}), 64'(3'b110));
      else if (cs_before && !hold)
         chk("len0_cs_off", 64'({busy, spi_valid, spi_ctrl, spi_wdata}), 64'({1'b1, 1'b1, 1'b0, 32'h0}));
      else
         chk("len0_done", 64'({done, busy, spi_valid}), 64'(3'b100));
   endtask

   // Reads leave wdata at its previous value; the model expects the byte just
   // written, which is what the preceding data write put there.
   function automatic logic [31:0] spi_wdata_dc_mask();
      return {24'h0, tx_stim_q[tx_stim_q.size()-1]};
   endfunction

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((exp_acc_q.size() != 0 || exp_rx_q.size() != 0 || done_pend != 0 ||
              tx_stim_q.size() != 0 || !cmd_ready) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_acc_q.size() != 0 || exp_rx_q.size() != 0 || done_pend != 0 || !cmd_ready)
         fail("idle_timeout");
   endtask

   initial begin : main
      int len;
      resetn         = 1'b0;
      cmd_valid      = 1'b0;
      cmd_len        = '0;
      cmd_hold_cs    = 1'b0;
      cmd_rx_discard = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'(outs()), 64'({1'b1, 50'd0}));
      @(posedge clk); #1;
      resetn = 1'b1;
      chk_en = 1'b1;

      fixed_tx_q.push_back(8'hA5);
      fixed_tx_q.push_back(8'h3C);
      issue(2, 1'b0, 1'b0);
      wait_idle(3000);

      issue(1, 1'b1, 1'b0);
      issue(1, 1'b0, 1'b0);
      wait_idle(3000);

      issue(3, 1'b0, 1'b1);
      wait_idle(3000);

      rx_mode = 2;
      issue(3, 1'b0, 1'b0);
      wait_idle(3000);
      rx_mode = 0;

      long_hold = 1'b1;
      issue(2, 1'b0, 1'b0);
      wait_idle(5000);
      long_hold = 1'b0;

      issue(0, 1'b0, 1'b0);
      issue(0, 1'b1, 1'b0);
      issue(2, 1'b1, 1'b0);
      issue(0, 1'b1, 1'b0);
      issue(0, 1'b0, 1'b0);
      wait_idle(3000);

      rx_mode = 1;
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 9) == 0) len = int'($urandom_range(10, 40));
         else len = int'($urandom_range(0, 5));
         issue(len, ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
      end
      wait_idle(20000);
      rx_mode = 0;

      issue(511, 1'b0, ($urandom_range(0, 1) == 1));
      wait_idle(30000);

      issue(5, 1'b0, 1'b0);
      repeat (30) @(negedge clk);
      chk("busy_before_reset", 64'(busy), 64'(1));
      chk_en = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      chk("async_reset_outputs", 64'(outs()), 64'({1'b1, 50'd0}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
